// File: rtl/dcache_ram_if.sv
// Dcache <-> data RAM refill/writeback bus: line request from the cache,
// completion pulse and refill line from the RAM responder.
interface dcache_ram_if #(
  parameter int LINE_WORDS = 4
);
  logic                    Dcache_req_ram_i;
  logic                    Dcache_we_ram_i;
  logic [31:0]             Dcache_addr_ram_i;
  logic [32*LINE_WORDS-1:0] Dcache_wdata_ram_i;
  logic                    ram_ready_o;
  logic [32*LINE_WORDS-1:0] ram_rdata_o;
  logic                    ram_busy_o;

  modport master (
    output Dcache_req_ram_i, Dcache_we_ram_i, Dcache_addr_ram_i, Dcache_wdata_ram_i,
    input  ram_ready_o, ram_rdata_o, ram_busy_o
  );

  modport slave (
    input  Dcache_req_ram_i, Dcache_we_ram_i, Dcache_addr_ram_i, Dcache_wdata_ram_i,
    output ram_ready_o, ram_rdata_o, ram_busy_o
  );
endinterface

// File: rtl/dcache_ram_resp.sv
// Data-RAM responder for Dcache line refills/writebacks: fixed access latency,
// one word per beat, single-cycle ram_ready_o pulse on completion.
module dcache_ram_resp #(
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic clk,
  input  logic rst_n,
  dcache_ram_if.slave bus
);

  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  LINE_MASK = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    base_q, base_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q;
  logic [31:0]         mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]    idx;
  logic                beat_en;
  logic                unused_addr;

  // Word index wraps at the array depth; low bits cleared for line alignment.
  assign idx         = base_q + IDX_W'(beat_q);
  assign beat_en     = (state_q == S_XFER);
  assign unused_addr = ^{bus.Dcache_addr_ram_i[31:IDX_W+2], bus.Dcache_addr_ram_i[1:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Dcache_req_ram_i) begin
          we_d    = bus.Dcache_we_ram_i;
          base_d  = bus.Dcache_addr_ram_i[IDX_W+1:2] & ~LINE_MASK;
          wdata_d = bus.Dcache_wdata_ram_i;
          lat_d   = '0;
          beat_d  = '0;
          state_d = (LATENCY > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = S_XFER;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_XFER: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    base_q  <= base_d;
    wdata_q <= wdata_d;
  end

  // A reset landing on a write beat suppresses that beat; earlier beats stay.
  always_ff @(posedge clk) begin
    if (rst_n && beat_en && we_q) begin
      mem_q[idx] <= wdata_q[32*beat_q +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (beat_en && !we_q) begin
      rdata_q[32*beat_q +: 32] <= mem_q[idx];
    end
  end

  assign bus.ram_ready_o = (state_q == S_DONE);
  assign bus.ram_busy_o  = (state_q != S_IDLE);
  assign bus.ram_rdata_o = rdata_q;

endmodule

// File: tb/tb_dcache_ram_resp.sv
// Directed bench for dcache_ram_resp: stimulus pushes expected completions into
// a scoreboard queue that a negedge monitor pops on every ram_ready_o pulse.
module tb_dcache_ram_resp;
  localparam int LW  = 4;
  localparam int LAT = 4;

  localparam logic [127:0] LINE_A = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE_B = {32'h80808083, 32'h80808082, 32'h80808081, 32'h80808080};
  localparam logic [127:0] LINE_C = {32'h5A5A0004, 32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001};
  localparam logic [127:0] LINE_D = {32'hD0000103, 32'hD0000102, 32'hD0000101, 32'hD0000100};
  localparam logic [127:0] LINE_X = {4{32'hAAAAAAAA}};
  localparam logic [127:0] LINE_P = {32'hD0000103, 32'hD0000102, 32'hAAAAAAAA, 32'hAAAAAAAA};

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_ram_if #(.LINE_WORDS(LW)) bus ();
  dcache_ram_if #(.LINE_WORDS(LW)) bus0 ();
  dcache_ram_if #(.LINE_WORDS(LW)) bus15 ();

  dcache_ram_resp #(.LINE_WORDS(LW), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  dcache_ram_resp #(.LINE_WORDS(LW), .DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  dcache_ram_resp #(.LINE_WORDS(LW), .DEPTH_WORDS(1024), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .bus(bus15)
  );

  typedef struct {
    logic         is_read;
    logic [127:0] rdata;
    int           lat;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: acceptance time of the main DUT and scoreboard pops on ready.
  int   acc_cyc = 0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.Dcache_req_ram_i && !bus.ram_busy_o) acc_cyc = cyc;
    if (rst_n && bus.ram_ready_o) begin
      chk("ready_prev_low", 128'(prev_ready), 128'(0));
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("ready_latency", 128'(cyc - acc_cyc), 128'(e.lat));
        if (e.is_read) chk("rdata", bus.ram_rdata_o, e.rdata);
      end
    end
    prev_ready = bus.ram_ready_o;
  end

  task automatic expect_txn(input logic is_read, input logic [127:0] rd);
    exp_t e;
    e.is_read = is_read;
    e.rdata   = rd;
    e.lat     = LAT + LW + 1;
    sbq.push_back(e);
  endtask

  task automatic wait_rdy(output int at_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ram_ready_o && n < 200);
    if (!bus.ram_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready within %0d cycles expected a pulse", n);
    end
    at_cyc = cyc;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                     input logic [127:0] exp_rd);
    int t;
    expect_txn(!we, exp_rd);
    @(posedge clk); #1;
    bus.Dcache_we_ram_i    = we;
    bus.Dcache_addr_ram_i  = addr;
    bus.Dcache_wdata_ram_i = wd;
    bus.Dcache_req_ram_i   = 1'b1;
    wait_rdy(t);
    @(posedge clk); #1;
    bus.Dcache_req_ram_i = 1'b0;
  endtask

  function automatic logic aux_ready(input int sel);
    return (sel == 0) ? bus0.ram_ready_o : bus15.ram_ready_o;
  endfunction

  task automatic aux_req(input int sel, input logic v);
    if (sel == 0) bus0.Dcache_req_ram_i = v;
    else          bus15.Dcache_req_ram_i = v;
  endtask

  task automatic lat_run(input int sel, input int exp_lat);
    int a;
    int n = 0;
    @(posedge clk); #1;
    aux_req(sel, 1'b1);
    a = cyc;
    do begin
      @(negedge clk);
      n++;
    end while (!aux_ready(sel) && n < 200);
    chk((sel == 0) ? "lat0_latency" : "lat15_latency", 128'(cyc - a), 128'(exp_lat));
    @(posedge clk); #1;
    aux_req(sel, 1'b0);
    @(negedge clk);
    chk((sel == 0) ? "lat0_pulse_width" : "lat15_pulse_width", 128'(aux_ready(sel)), 128'(0));
  endtask

  initial begin
    int   r1, r2, n;
    logic busy_ok;

    rst_n = 1'b0;
    bus.Dcache_req_ram_i = 1'b0;  bus.Dcache_we_ram_i = 1'b0;
    bus.Dcache_addr_ram_i = '0;   bus.Dcache_wdata_ram_i = '0;
    bus0.Dcache_req_ram_i = 1'b0; bus0.Dcache_we_ram_i = 1'b0;
    bus0.Dcache_addr_ram_i = 32'h40; bus0.Dcache_wdata_ram_i = '0;
    bus15.Dcache_req_ram_i = 1'b0; bus15.Dcache_we_ram_i = 1'b0;
    bus15.Dcache_addr_ram_i = 32'h40; bus15.Dcache_wdata_ram_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 128'(bus.ram_ready_o), 128'(0));
    chk("reset_busy",  128'(bus.ram_busy_o),  128'(0));
    chk("reset_rdata", bus.ram_rdata_o, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write/read round trip, then an unrelated write must not disturb rdata.
    txn(1'b1, 32'h0000_0040, LINE_A, '0);
    txn(1'b0, 32'h0000_0040, '0, LINE_A);
    txn(1'b1, 32'h0000_0080, LINE_B, '0);
    @(negedge clk);
    chk("rdata_hold", bus.ram_rdata_o, LINE_A);

    // Unaligned address and depth wrap alias onto line 0x40.
    txn(1'b1, 32'h0000_004C, LINE_C, '0);
    txn(1'b0, 32'h0000_0040, '0, LINE_C);
    txn(1'b0, 32'h0000_1040, '0, LINE_B ^ LINE_B ^ LINE_C);

    // Inputs changed mid-read must be ignored.
    expect_txn(1'b1, LINE_C);
    @(posedge clk); #1;
    bus.Dcache_we_ram_i = 1'b0;
    bus.Dcache_addr_ram_i = 32'h0000_0040;
    bus.Dcache_req_ram_i = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    bus.Dcache_addr_ram_i = 32'h0000_0080;
    bus.Dcache_we_ram_i = 1'b1;
    bus.Dcache_wdata_ram_i = {4{32'hDEADBEEF}};
    busy_ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.ram_busy_o) busy_ok = 1'b0;
    end while (!bus.ram_ready_o && n < 200);
    chk("busy_held", 128'(busy_ok), 128'(1));
    @(posedge clk); #1;
    bus.Dcache_req_ram_i = 1'b0;
    bus.Dcache_we_ram_i = 1'b0;
    txn(1'b0, 32'h0000_0080, '0, LINE_B);

    // Back-to-back reads with req held high throughout.
    expect_txn(1'b1, LINE_C);
    expect_txn(1'b1, LINE_B);
    @(posedge clk); #1;
    bus.Dcache_we_ram_i = 1'b0;
    bus.Dcache_addr_ram_i = 32'h0000_0040;
    bus.Dcache_req_ram_i = 1'b1;
    wait_rdy(r1);
    @(posedge clk); #1;
    bus.Dcache_addr_ram_i = 32'h0000_0080;
    wait_rdy(r2);
    @(posedge clk); #1;
    bus.Dcache_req_ram_i = 1'b0;
    chk("b2b_spacing", 128'(r2 - r1), 128'(LAT + LW + 2));

    // Reset during beat 2 of a writeback: beats 0-1 land, 2-3 do not.
    txn(1'b1, 32'h0000_0100, LINE_D, '0);
    @(posedge clk); #1;
    bus.Dcache_we_ram_i = 1'b1;
    bus.Dcache_addr_ram_i = 32'h0000_0100;
    bus.Dcache_wdata_ram_i = LINE_X;
    bus.Dcache_req_ram_i = 1'b1;
    repeat (LAT + 3 + 1) @(negedge clk);
    rst_n = 1'b0;
    bus.Dcache_req_ram_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 128'(bus.ram_ready_o), 128'(0));
    chk("midrst_busy",  128'(bus.ram_busy_o),  128'(0));
    chk("midrst_rdata", bus.ram_rdata_o, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    txn(1'b0, 32'h0000_0100, '0, LINE_P);

    // Latency extremes on dedicated instances.
    lat_run(0, 0 + LW + 1);
    lat_run(1, 15 + LW + 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1);
  end
endmodule
